shift_feeder: RTL and testbench



---
 rtl/shift_feeder_pkg.sv | 21 ++
 rtl/shift_feeder_if.sv | 24 ++
 rtl/shift_feeder_bit_tick_gen.sv | 38 +++
 rtl/shift_feeder.sv | 106 ++++++++++
 tb/tb_shift_feeder.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_feeder_pkg.sv
// Shared definitions for the shift feeder and the downstream shift register.
package shift_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        DONE = ST_DONE
    } state_t;

    // Counter width for a modulus n, never less than one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_feeder_if.sv
// Load handshake plus serial outputs of the shift feeder.
interface shift_feeder_if
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             shr;
    logic             shr_in;
    logic             busy;
    logic             done;

    modport master (
        output data_in, load_valid,
        input  load_ready, shr, shr_in, busy, done
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, shr, shr_in, busy, done
    );
endinterface

// File: rtl/shift_feeder_bit_tick_gen.sv
// DIV prescaler built as a down-counter; tick is asserted one cycle ahead of the
// counter reaching zero so the feeder can register its strobe onto that cycle.
module bit_tick_gen
    import shift_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tick
);
    localparam int            CW     = cnt_bits(DIV);
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = RELOAD;
        end else if (en) begin
            cnt_next = (cnt == '0) ? RELOAD : cnt - CW'(1);
        end
    end

    assign tick = (load || en) && (cnt_next == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end
endmodule

// File: rtl/shift_feeder.sv
// Parallel-to-serial feeder: accepts a word and strobes it LSB first into a
// right-shift register, one bit every DIV clocks, then pulses done.
//
//   state | meaning
//   IDLE  | load_ready high, waiting for load_valid
//   SEND  | prescaler running, one shr strobe per bit
//   DONE  | one-cycle done pulse, back to IDLE
module shift_feeder
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV   = 1
) (
    input logic           clk,
    input logic           rst,
    shift_feeder_if.slave bus
);
    localparam int BW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] buffer;
    logic [BW-1:0]    bit_cnt;
    logic             shr_q;
    logic             shr_in_q;
    logic             done_q;
    logic             busy_q;
    logic             ready_q;

    logic accept;
    logic last;
    logic tick_en;
    logic tick;
    logic second_bit;
    logic next_bit;

    if (WIDTH > 1) begin : g_wide
        assign second_bit = buffer[1];
    end else begin : g_narrow
        assign second_bit = 1'b0;
    end

    assign accept  = (state == IDLE) && bus.load_valid;
    assign last    = (bit_cnt == BW'(WIDTH - 1));
    // Stop the prescaler during the final strobe so no extra tick reaches DONE.
    assign tick_en = (state == SEND) && !(shr_q && last);
    // Bit that will sit in buffer[0] during the next cycle.
    assign next_bit = accept ? bus.data_in[0] : (shr_q ? second_bit : buffer[0]);

    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .en   (tick_en),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            buffer   <= '0;
            bit_cnt  <= '0;
            shr_q    <= 1'b0;
            shr_in_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            shr_q    <= tick;
            shr_in_q <= tick & next_bit;
            done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        buffer  <= bus.data_in;
                        bit_cnt <= '0;
                        state   <= SEND;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                SEND: begin
                    if (shr_q) begin
                        buffer  <= buffer >> 1;
                        bit_cnt <= bit_cnt + BW'(1);
                        if (last) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.shr        = shr_q;
    assign bus.shr_in     = shr_in_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.load_ready = ready_q;
endmodule

// File: tb/tb_shift_feeder.sv
// Directed bench for shift_feeder with DIV=1 and DIV=3 instances feeding
// modelled 4-bit right-shift registers.
module tb_shift_feeder;
    logic clk;
    logic rst;

    shift_feeder_if #(.WIDTH(4)) bus_a ();
    shift_feeder_if #(.WIDTH(4)) bus_b ();

    shift_feeder #(.WIDTH(4), .DIV(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    shift_feeder #(.WIDTH(4), .DIV(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    logic [3:0] q_a;
    logic [3:0] q_b;

    // Downstream registers: shift toward bit 0, insert at MSB.
    always @(posedge clk) begin
        if (rst) q_a <= '0;
        else if (bus_a.shr) q_a <= {bus_a.shr_in, q_a[3:1]};
    end
    always @(posedge clk) begin
        if (rst) q_b <= '0;
        else if (bus_b.shr) q_b <= {bus_b.shr_in, q_b[3:1]};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] data;
        logic [3:0] bits;   // bit k = expected shr_in on strobe k
        logic [3:0] exp_q;
    } vec_t;

    vec_t vecs[4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        check($sformatf("v%0d_ready0", idx), 32'(bus_a.load_ready), 32'd1);
        bus_a.data_in    = v.data;
        bus_a.load_valid = 1'b1;
        step();
        bus_a.load_valid = 1'b0;
        bus_a.data_in    = ~v.data;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("v%0d_shr_c%0d", idx, c), 32'(bus_a.shr), 32'((c <= 4) ? 1 : 0));
            check($sformatf("v%0d_shr_in_c%0d", idx, c), 32'(bus_a.shr_in),
                  32'((c <= 4) ? v.bits[c-1] : 1'b0));
            check($sformatf("v%0d_done_c%0d", idx, c), 32'(bus_a.done), 32'((c == 5) ? 1 : 0));
            check($sformatf("v%0d_busy_c%0d", idx, c), 32'(bus_a.busy), 32'((c <= 5) ? 1 : 0));
            check($sformatf("v%0d_ready_c%0d", idx, c), 32'(bus_a.load_ready), 32'((c == 6) ? 1 : 0));
            if (c == 5) check($sformatf("v%0d_q", idx), 32'(q_a), 32'(v.exp_q));
            if (c < 6) step();
        end
    endtask

    initial begin
        int n;
        int d;
        logic [3:0] exp_bits;

        vecs[0] = '{data: 4'b1011, bits: 4'b1011, exp_q: 4'b1011};
        vecs[1] = '{data: 4'b0000, bits: 4'b0000, exp_q: 4'b0000};
        vecs[2] = '{data: 4'b1111, bits: 4'b1111, exp_q: 4'b1111};
        vecs[3] = '{data: 4'b1000, bits: 4'b1000, exp_q: 4'b1000};

        bus_a.data_in = '0; bus_a.load_valid = 1'b0;
        bus_b.data_in = '0; bus_b.load_valid = 1'b0;

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_ready_a", 32'(bus_a.load_ready), 32'd1);
        check("rst_shr_a", 32'(bus_a.shr), 32'd0);
        check("rst_shr_in_a", 32'(bus_a.shr_in), 32'd0);
        check("rst_busy_a", 32'(bus_a.busy), 32'd0);
        check("rst_done_a", 32'(bus_a.done), 32'd0);
        check("rst_ready_b", 32'(bus_b.load_ready), 32'd1);
        check("rst_shr_b", 32'(bus_b.shr), 32'd0);
        check("rst_busy_b", 32'(bus_b.busy), 32'd0);

        // Table-driven DIV=1 transfers
        for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

        // Prescaler, DIV=3
        exp_bits = 4'b0110;
        check("div3_ready0", 32'(bus_b.load_ready), 32'd1);
        bus_b.data_in    = 4'b0110;
        bus_b.load_valid = 1'b1;
        step();
        bus_b.load_valid = 1'b0;
        bus_b.data_in    = 4'b1001;
        for (int c = 1; c <= 14; c++) begin
            check($sformatf("div3_shr_c%0d", c), 32'(bus_b.shr),
                  32'(((c % 3) == 0 && c <= 12) ? 1 : 0));
            check($sformatf("div3_shr_in_c%0d", c), 32'(bus_b.shr_in),
                  32'(((c % 3) == 0 && c <= 12) ? exp_bits[c/3-1] : 1'b0));
            check($sformatf("div3_done_c%0d", c), 32'(bus_b.done), 32'((c == 13) ? 1 : 0));
            check($sformatf("div3_ready_c%0d", c), 32'(bus_b.load_ready), 32'((c == 14) ? 1 : 0));
            if (c == 13) check("div3_q", 32'(q_b), 32'h6);
            if (c < 14) step();
        end

        // Back-to-back with load_valid held high
        check("b2b_ready0", 32'(bus_a.load_ready), 32'd1);
        bus_a.data_in    = 4'hA;
        bus_a.load_valid = 1'b1;
        step();
        bus_a.data_in = 4'h5;
        n = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 7) bus_a.load_valid = 1'b0;
            n += int'(bus_a.shr);
            if (c == 5) begin
                check("b2b_q_first", 32'(q_a), 32'hA);
                check("b2b_done_first", 32'(bus_a.done), 32'd1);
            end
            if (c == 6) check("b2b_ready_c6", 32'(bus_a.load_ready), 32'd1);
            if (c == 7) begin
                check("b2b_shr_c7", 32'(bus_a.shr), 32'd1);
                check("b2b_ready_c7", 32'(bus_a.load_ready), 32'd0);
            end
            if (c == 11) begin
                check("b2b_q_second", 32'(q_a), 32'h5);
                check("b2b_done_second", 32'(bus_a.done), 32'd1);
            end
            if (c == 12) check("b2b_ready_c12", 32'(bus_a.load_ready), 32'd1);
            step();
        end
        check("b2b_strobes", 32'(n), 32'd8);

        // load_valid during SEND is ignored
        exp_bits = 4'b0011;
        check("ign_ready0", 32'(bus_a.load_ready), 32'd1);
        bus_a.data_in    = 4'h3;
        bus_a.load_valid = 1'b1;
        step();
        bus_a.load_valid = 1'b0;
        n = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) begin
                bus_a.load_valid = 1'b1;
                bus_a.data_in    = 4'hF;
            end
            if (c == 3) bus_a.load_valid = 1'b0;
            n += int'(bus_a.shr);
            if (c <= 4) check($sformatf("ign_shr_in_c%0d", c), 32'(bus_a.shr_in), 32'(exp_bits[c-1]));
            if (c == 5) check("ign_q", 32'(q_a), 32'h3);
            step();
        end
        check("ign_strobes", 32'(n), 32'd4);
        check("ign_ready_end", 32'(bus_a.load_ready), 32'd1);

        // Reset mid-transfer
        bus_a.data_in    = 4'b1101;
        bus_a.load_valid = 1'b1;
        step();
        bus_a.load_valid = 1'b0;
        check("mid_shr_c1", 32'(bus_a.shr), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_shr_c3", 32'(bus_a.shr), 32'd0);
        check("mid_shr_in_c3", 32'(bus_a.shr_in), 32'd0);
        check("mid_busy_c3", 32'(bus_a.busy), 32'd0);
        check("mid_ready_c3", 32'(bus_a.load_ready), 32'd1);
        check("mid_q_c3", 32'(q_a), 32'd0);
        n = 0;
        d = 0;
        for (int c = 3; c <= 10; c++) begin
            n += int'(bus_a.shr);
            d += int'(bus_a.done);
            step();
        end
        check("mid_strobes", 32'(n), 32'd0);
        check("mid_done", 32'(d), 32'd0);
        check("mid_q_end", 32'(q_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
